// File: rtl/score_ctrl_pkg.sv
// rtl/score_ctrl_pkg.sv - shared game defines and constants for score_ctrl
`ifndef SCORE_CTRL_DEFINES
`define SCORE_CTRL_DEFINES
`define GAME_STATUS_BIT_LEN 2
`define GAME_STATUS_IDLE    2'd0
`define GAME_STATUS_RUN     2'd1
`define GAME_STATUS_OVER    2'd2
`define ADD_SCORE_BIT_WIDTH 4
`define SCORE_WIDTH_DEC     12
`define SCORE_W_SMALL       1
`define SCORE_W_MID         3
`define SCORE_W_BIG         5
`endif

package score_ctrl_pkg;
  localparam int STATUS_W = `GAME_STATUS_BIT_LEN;
  localparam int ADD_W    = `ADD_SCORE_BIT_WIDTH;
  localparam int SCORE_W  = `SCORE_WIDTH_DEC;

  localparam logic [STATUS_W-1:0] ST_RUN = `GAME_STATUS_RUN;

  localparam int W_SMALL = `SCORE_W_SMALL;
  localparam int W_MID   = `SCORE_W_MID;
  localparam int W_BIG   = `SCORE_W_BIG;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/score_ctrl_rr_arbiter.sv
// rtl/score_ctrl_rr_arbiter.sv - combinational round-robin arbiter
// Searches upward from ptr (wrapping) and grants the first active request.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);
  int  idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - kill-event score arbitration, pacing and hi-score tracking
// Serialises weighted point additions so the score counter can drain between them.
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W0   = W_SMALL,
  parameter int W1   = W_MID,
  parameter int W2   = W_BIG
) (
  input  logic                clk_vga,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_i,
  output logic [NREQ-1:0]     ack_o,
  input  logic [STATUS_W-1:0] game_status_i,
  input  logic [SCORE_W-1:0]  score_i,
  output logic [ADD_W-1:0]    add_score_o,
  output logic                score_clr_o,
  output logic [SCORE_W-1:0]  hi_score_o,
  output logic                busy_o
);
  localparam int PTR_W = ptr_width(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_PACE  = 2'd2;

  logic [1:0]          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [NREQ-1:0]     grant;
  logic [ADD_W-1:0]    grant_w;
  logic [ADD_W-1:0]    pace_cnt;
  logic [STATUS_W-1:0] prev_status;
  logic                is_run;
  logic                prev_run;

  function automatic logic [ADD_W-1:0] weight_of(input int idx);
    if (idx == 0) return ADD_W'(W0);
    if (idx == 1) return ADD_W'(W1);
    return ADD_W'(W2);
  endfunction

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    grant_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_idx = PTR_W'(i);
        grant_w = weight_of(i);
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign is_run   = (game_status_i == ST_RUN);
  assign prev_run = (prev_status == ST_RUN);

  // The grant is only ever offered from IDLE; the cycle carrying it already counts as busy.
  assign ack_o  = (state == S_IDLE && !rst) ? grant : '0;
  assign busy_o = (state != S_IDLE) || (|ack_o);

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      add_score_o <= '0;
      pace_cnt    <= '0;
    end else begin
      add_score_o <= '0;
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            state  <= S_ISSUE;
            rr_ptr <= next_ptr;
            if (is_run) add_score_o <= grant_w;
          end
        end
        S_ISSUE: begin
          // A discarded (non-RUN) grant carries zero points and skips pacing.
          pace_cnt <= add_score_o;
          state    <= (add_score_o != '0) ? S_PACE : S_IDLE;
        end
        S_PACE: begin
          pace_cnt <= pace_cnt - 1'b1;
          if (pace_cnt <= ADD_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      prev_status <= ST_RUN;
      score_clr_o <= 1'b0;
      hi_score_o  <= '0;
    end else begin
      prev_status <= game_status_i;
      score_clr_o <= is_run && !prev_run;
      if (prev_run && !is_run && (score_i > hi_score_o)) hi_score_o <= score_i;
    end
  end
endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - self-checking bench for score_ctrl
module tb_score_ctrl;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  logic        clk_vga = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_i = 3'b111;
  logic [1:0]  game_status_i = ST_RUN;
  logic [11:0] score_i = '0;
  logic [2:0]  ack_o;
  logic [3:0]  add_score_o;
  logic        score_clr_o;
  logic [11:0] hi_score_o;
  logic        busy_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_vga = ~clk_vga;

  score_ctrl dut (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .req_i         (req_i),
    .ack_o         (ack_o),
    .game_status_i (game_status_i),
    .score_i       (score_i),
    .add_score_o   (add_score_o),
    .score_clr_o   (score_clr_o),
    .hi_score_o    (hi_score_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Timeline model: a grant at cycle c makes the block free again at c+w+2 (RUN) or c+2.
  int          wt [3] = '{1, 3, 5};
  int          cyc = 0;
  int          idle_at = 0;
  int          ptr_m = 0;
  int          add_next = 0;
  bit          clr_next = 1'b0;
  logic [11:0] hi_m = '0;
  logic [1:0]  prev_m = ST_RUN;
  int          win;
  logic [2:0]  exp_ack;

  always @(negedge clk_vga) begin
    if (rst) begin
      idle_at  = 0;
      ptr_m    = 0;
      add_next = 0;
      clr_next = 1'b0;
      hi_m     = '0;
      prev_m   = ST_RUN;
      chk("m_rst_ack", ack_o, 0);
      chk("m_rst_busy", busy_o, 0);
      chk("m_rst_add", add_score_o, 0);
      chk("m_rst_clr", score_clr_o, 0);
      chk("m_rst_hi", hi_score_o, 0);
    end else begin
      win = -1;
      if (cyc >= idle_at)
        for (int k = 0; k < 3; k++)
          if (win < 0 && req_i[(ptr_m + k) % 3]) win = (ptr_m + k) % 3;
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("m_ack", ack_o, exp_ack);
      chk("m_busy", busy_o, (cyc < idle_at) || (win >= 0));
      chk("m_add", add_score_o, add_next);
      chk("m_clr", score_clr_o, clr_next);
      chk("m_hi", hi_score_o, hi_m);
      add_next = (win >= 0 && game_status_i == ST_RUN) ? wt[win] : 0;
      if (win >= 0) begin
        idle_at = cyc + ((game_status_i == ST_RUN) ? wt[win] + 2 : 2);
        ptr_m   = (win + 1) % 3;
      end
      clr_next = (game_status_i == ST_RUN) && (prev_m != ST_RUN);
      if (prev_m == ST_RUN && game_status_i != ST_RUN && score_i > hi_m) hi_m = score_i;
      prev_m = game_status_i;
    end
    cyc++;
  end

  task automatic drive_slot();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_vga);
    #2;
  endtask

  task automatic wait_ack(output logic [2:0] a);
    a = '0;
    for (int i = 0; i < 20 && a == 3'b000; i++) begin
      sample();
      a = ack_o;
    end
    chk("ack_wait", (a != 3'b000), 1);
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    logic [2:0] a;
    int busy_cnt, clr_cnt, nz_cnt;
    int ack_idx[$], add_cyc[$], add_val[$];

    repeat (3) sample();
    chk("reset_ack_gated", ack_o, 3'b000);
    chk("reset_busy", busy_o, 0);
    chk("reset_hi", hi_score_o, 0);

    drive_slot();
    rst = 1'b0;
    req_i = 3'b000;
    clr_cnt = 0;
    repeat (4) begin sample(); clr_cnt += score_clr_o; end
    chk("no_clr_after_rst", clr_cnt, 0);

    // single mid-size kill
    drive_slot();
    req_i = 3'b010;
    wait_ack(a);
    chk("mid_ack", a, 3'b010);
    drive_slot();
    req_i = 3'b000;
    busy_cnt = 1;
    for (int k = 1; k <= 8; k++) begin
      sample();
      if (k == 1) chk("mid_add", add_score_o, 3);
      busy_cnt += busy_o;
    end
    chk("mid_busy_cycles", busy_cnt, 5);

    // round robin from a fresh pointer with all requesters held
    drive_slot();
    rst = 1'b1;
    sample();
    drive_slot();
    rst = 1'b0;
    req_i = 3'b111;
    for (int s = 0; s < 40; s++) begin
      sample();
      if (ack_o != 3'b000) ack_idx.push_back(oh_idx(ack_o));
      if (add_score_o != 0) begin
        add_cyc.push_back(s);
        add_val.push_back(int'(add_score_o));
      end
    end
    drive_slot();
    req_i = 3'b000;
    chk("rr_ack0", qget(ack_idx, 0), 0);
    chk("rr_ack1", qget(ack_idx, 1), 1);
    chk("rr_ack2", qget(ack_idx, 2), 2);
    chk("rr_ack3", qget(ack_idx, 3), 0);
    chk("rr_add0", qget(add_val, 0), 1);
    chk("rr_add1", qget(add_val, 1), 3);
    chk("rr_add2", qget(add_val, 2), 5);
    chk("rr_add3", qget(add_val, 3), 1);
    chk("rr_gap0", qget(add_cyc, 1) - qget(add_cyc, 0), 3);
    chk("rr_gap1", qget(add_cyc, 2) - qget(add_cyc, 1), 5);
    chk("rr_gap2", qget(add_cyc, 3) - qget(add_cyc, 2), 7);
    repeat (10) sample();

    // game over records the high score
    drive_slot();
    score_i = 12'h042;
    drive_slot();
    game_status_i = ST_OVER;
    repeat (2) sample();
    chk("hi_first", hi_score_o, 12'h042);

    // kill while not running: acked, no points
    drive_slot();
    req_i = 3'b100;
    wait_ack(a);
    chk("over_ack", a, 3'b100);
    drive_slot();
    req_i = 3'b000;
    nz_cnt = 0;
    repeat (6) begin sample(); nz_cnt += (add_score_o != 0); end
    chk("over_no_add", nz_cnt, 0);

    // new game clears the score once
    drive_slot();
    game_status_i = ST_RUN;
    clr_cnt = 0;
    repeat (4) begin sample(); clr_cnt += score_clr_o; end
    chk("clr_pulse_count", clr_cnt, 1);

    // lower score does not replace the record
    drive_slot();
    score_i = 12'h017;
    drive_slot();
    game_status_i = ST_OVER;
    repeat (3) sample();
    chk("hi_kept", hi_score_o, 12'h042);
    drive_slot();
    game_status_i = ST_RUN;
    repeat (3) sample();

    // reset in the middle of pacing a big kill
    drive_slot();
    req_i = 3'b100;
    wait_ack(a);
    chk("big_ack", a, 3'b100);
    drive_slot();
    req_i = 3'b000;
    repeat (3) sample();
    drive_slot();
    rst = 1'b1;
    req_i = 3'b111;
    sample();
    chk("midpace_rst_busy", busy_o, 0);
    chk("midpace_rst_ack", ack_o, 3'b000);
    chk("midpace_rst_add", add_score_o, 0);
    chk("midpace_rst_hi", hi_score_o, 0);
    drive_slot();
    rst = 1'b0;
    wait_ack(a);
    chk("post_rst_first_ack", a, 3'b001);
    drive_slot();
    req_i = 3'b000;
    repeat (10) sample();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
